// File: rtl/ebpc_pkg.sv
// Shared EBPC decoder package: sizing constants, arbiter state type
// and a small modulo helper used for round-robin pointer arithmetic.
package ebpc_pkg;

   localparam int unsigned LOG_MAX_WORDS = 8;
   localparam int unsigned DATA_W        = 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ISSUE  = 2'd1,
      ARB_ACTIVE = 2'd2
   } arb_state_e;

   function automatic int unsigned rr_wrap(
      input int unsigned base,
      input int unsigned off,
      input int unsigned n
   );
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/ebpc_job_arbiter_if.sv
// Job arbiter bundle: requester jobs, decoder num_words handshake,
// decoder output monitor and grant/completion status.
interface ebpc_job_arbiter_if #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) ();
   import ebpc_pkg::*;

   logic [N_REQ-1:0][LOG_MAX_WORDS-1:0] req_num_words_i;
   logic [N_REQ-1:0]                    req_vld_i;
   logic [N_REQ-1:0]                    req_rdy_o;
   logic [LOG_MAX_WORDS-1:0]            dec_num_words_o;
   logic                                dec_num_words_vld_o;
   logic                                dec_num_words_rdy_i;
   logic                                mon_vld_i;
   logic                                mon_rdy_i;
   logic                                mon_last_i;
   logic [ID_W-1:0]                     owner_o;
   logic                                busy_o;
   logic                                done_o;
   logic [ID_W-1:0]                     done_id_o;
`ifdef EBPC_ARB_LEN_CHECK_EN
   logic                                len_err_o;
`endif

   modport master (
      output req_num_words_i, req_vld_i,
      output dec_num_words_rdy_i,
      output mon_vld_i, mon_rdy_i, mon_last_i,
      input  req_rdy_o, dec_num_words_o,
      input  dec_num_words_vld_o,
      input  owner_o, busy_o, done_o, done_id_o
`ifdef EBPC_ARB_LEN_CHECK_EN
      , input len_err_o
`endif
   );

   modport slave (
      input  req_num_words_i, req_vld_i,
      input  dec_num_words_rdy_i,
      input  mon_vld_i, mon_rdy_i, mon_last_i,
      output req_rdy_o, dec_num_words_o,
      output dec_num_words_vld_o,
      output owner_o, busy_o, done_o, done_id_o
`ifdef EBPC_ARB_LEN_CHECK_EN
      , output len_err_o
`endif
   );

endinterface

// File: rtl/rr_arb_sel.sv
// Round-robin selector: first asserted request at or after ptr_i,
// wrapping modulo N_REQ. Purely combinational.
module rr_arb_sel
   import ebpc_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic             vld_o,
   output logic [ID_W-1:0]  idx_o
);

   int unsigned k;

   // scan from the pointer, first hit wins
   always_comb begin
      vld_o = 1'b0;
      idx_o = '0;
      k     = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = rr_wrap(32'(ptr_i), i, N_REQ);
         if (!vld_o && req_i[k[ID_W-1:0]]) begin
            vld_o = 1'b1;
            idx_o = k[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ebpc_job_arbiter.sv
// Shares one EBPC decoder among N_REQ requesters, one job in flight.
// Optional length check enabled by defining EBPC_ARB_LEN_CHECK_EN.
module ebpc_job_arbiter
   import ebpc_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input logic          clk_i,
   input logic          rst_ni,
   ebpc_job_arbiter_if.slave bus
);

   arb_state_e               state_q;
   logic [ID_W-1:0]          rr_ptr_q;
   logic [ID_W-1:0]          owner_q;
   logic [LOG_MAX_WORDS-1:0] len_q;
   logic [ID_W-1:0]          sel_idx;
   logic                     sel_vld;
   logic                     grant;
   logic                     last_beat;
`ifdef EBPC_ARB_LEN_CHECK_EN
   logic [LOG_MAX_WORDS:0]   cnt_q;
   logic                     beat;
`endif

   rr_arb_sel #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_sel (
      .req_i (bus.req_vld_i),
      .ptr_i (rr_ptr_q),
      .vld_o (sel_vld),
      .idx_o (sel_idx)
   );

   // rdy must pair with vld in the same cycle; held low while in reset
   assign grant     = rst_ni && sel_vld && (state_q == ARB_IDLE);
   assign last_beat = (state_q == ARB_ACTIVE) && bus.mon_vld_i
                      && bus.mon_rdy_i && bus.mon_last_i;

   // one-hot ready toward the granted requester only
   always_comb begin
      bus.req_rdy_o = '0;
      if (grant) bus.req_rdy_o[sel_idx] = 1'b1;
   end

   assign bus.dec_num_words_o     = len_q;
   assign bus.dec_num_words_vld_o = (state_q == ARB_ISSUE);
   assign bus.owner_o             = grant ? sel_idx : owner_q;
   assign bus.busy_o              = (state_q != ARB_IDLE);
   assign bus.done_o              = last_beat;
   assign bus.done_id_o           = owner_q;

`ifdef EBPC_ARB_LEN_CHECK_EN
   assign beat          = bus.mon_vld_i && bus.mon_rdy_i;
   assign bus.len_err_o = last_beat && (cnt_q != {1'b0, len_q});
`endif

   // job FSM: grant, issue length, wait for the last output beat
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         len_q    <= '0;
`ifdef EBPC_ARB_LEN_CHECK_EN
         cnt_q    <= '0;
`endif
      end else begin
         unique case (state_q)
            ARB_IDLE: begin
               if (sel_vld) begin
                  owner_q <= sel_idx;
                  len_q   <= bus.req_num_words_i[sel_idx];
                  state_q <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (bus.dec_num_words_rdy_i) begin
                  state_q <= ARB_ACTIVE;
`ifdef EBPC_ARB_LEN_CHECK_EN
                  cnt_q   <= '0;
`endif
               end
            end
            ARB_ACTIVE: begin
`ifdef EBPC_ARB_LEN_CHECK_EN
               if (beat && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
`endif
               if (last_beat) begin
                  rr_ptr_q <= ID_W'(rr_wrap(32'(owner_q), 1, N_REQ));
                  state_q  <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ebpc_job_arbiter.sv
// Scoreboard bench for ebpc_job_arbiter (N_REQ=3): expected jobs are
// queued when requests are raised and checked as grants complete.
`timescale 1ns/1ps
module tb_ebpc_job_arbiter;
   import ebpc_pkg::*;

   localparam int unsigned NR = 3;
   localparam int unsigned IW = 2;

   typedef struct {
      int id;
      int len;
      int beats;
   } job_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   bit   keep [NR];
   job_t exp_q [$];

   ebpc_job_arbiter_if #(.N_REQ(NR), .ID_W(IW)) bus ();

   ebpc_job_arbiter #(
      .N_REQ (NR),
      .ID_W  (IW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int id, input int len, input int beats);
      job_t j;
      j.id    = id;
      j.len   = len;
      j.beats = beats;
      exp_q.push_back(j);
      bus.req_num_words_i[id] = LOG_MAX_WORDS'(len);
      bus.req_vld_i[id]       = 1'b1;
   endtask

   // serve the next grant; abort>0 resets after that many beats
   task automatic serve(input int stall, input int abort);
      job_t j;
      bit   got;
      logic [LOG_MAX_WORDS-1:0] orig;
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (n == 0) chk("idle_busy", bus.busy_o, 0);
         if (|bus.req_rdy_o) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("grant_timeout", 0, 1);
         return;
      end
      if (exp_q.size() == 0) begin
         chk("sb_empty", 0, 1);
         return;
      end
      j = exp_q.pop_front();
      chk("rdy_onehot", bus.req_rdy_o, 1 << j.id);
      chk("grant_owner", bus.owner_o, j.id);
      @(posedge clk); #1;
      if (!keep[j.id]) bus.req_vld_i[j.id] = 1'b0;
      orig = bus.req_num_words_i[j.id];
      bus.req_num_words_i[j.id] = ~orig;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_vld", bus.dec_num_words_vld_o, 1);
         chk("stall_len", bus.dec_num_words_o, j.len);
         chk("stall_rdy", bus.req_rdy_o, 0);
         @(posedge clk); #1;
      end
      bus.dec_num_words_rdy_i = 1'b1;
      @(negedge clk);
      chk("iss_vld", bus.dec_num_words_vld_o, 1);
      chk("iss_len", bus.dec_num_words_o, j.len);
      chk("iss_busy", bus.busy_o, 1);
      @(posedge clk); #1;
      bus.dec_num_words_rdy_i = 1'b0;
      bus.mon_vld_i  = 1'b1;
      bus.mon_rdy_i  = 1'b0;
      bus.mon_last_i = 1'b1;
      @(negedge clk);
      chk("act_vld", bus.dec_num_words_vld_o, 0);
      chk("stalled_last", bus.done_o, 0);
      @(posedge clk); #1;
      for (int b = 1; b <= j.beats; b++) begin
         if (abort > 0 && b == abort + 1) begin
            bus.mon_vld_i  = 1'b0;
            bus.mon_rdy_i  = 1'b0;
            bus.mon_last_i = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            chk("rst_busy", bus.busy_o, 0);
            chk("rst_done", bus.done_o, 0);
            chk("rst_owner", bus.owner_o, 0);
            chk("rst_dvld", bus.dec_num_words_vld_o, 0);
            chk("rst_len", bus.dec_num_words_o, 0);
            bus.req_num_words_i[j.id] = orig;
            return;
         end
         bus.mon_vld_i  = 1'b1;
         bus.mon_rdy_i  = 1'b1;
         bus.mon_last_i = (b == j.beats);
         @(negedge clk);
         chk("done", bus.done_o, b == j.beats);
         chk("act_owner", bus.owner_o, j.id);
         chk("act_rdy", bus.req_rdy_o, 0);
         if (b == j.beats) chk("done_id", bus.done_id_o, j.id);
`ifdef EBPC_ARB_LEN_CHECK_EN
         chk("len_err", bus.len_err_o,
             (b == j.beats) && (j.beats - 1 != j.len));
`endif
         @(posedge clk); #1;
      end
      bus.mon_vld_i  = 1'b0;
      bus.mon_rdy_i  = 1'b0;
      bus.mon_last_i = 1'b0;
      bus.req_num_words_i[j.id] = orig;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      foreach (keep[i]) keep[i] = 1'b0;
      rst_n = 1'b0;
      bus.req_num_words_i     = '0;
      bus.req_vld_i           = '0;
      bus.dec_num_words_rdy_i = 1'b0;
      bus.mon_vld_i           = 1'b0;
      bus.mon_rdy_i           = 1'b0;
      bus.mon_last_i          = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", bus.busy_o, 0);
      chk("reset_rdy", bus.req_rdy_o, 0);
      chk("reset_owner", bus.owner_o, 0);
      chk("reset_dvld", bus.dec_num_words_vld_o, 0);
      chk("reset_done", bus.done_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single job, req0 len=3, four beats
      push(0, 3, 4);
      serve(0, 0);

      // decoder stall of 5 cycles, ptr=1 -> req2
      push(2, 5, 6);
      serve(5, 0);

      // contention between req0 and req1, ptr=0
      keep[0] = 1'b1;
      keep[1] = 1'b1;
      push(0, 1, 2);
      push(1, 2, 3);
      push(0, 1, 2);
      push(1, 2, 3);
      for (int i = 0; i < 4; i++) serve(0, 0);
      bus.req_vld_i = '0;
      keep[0] = 1'b0;
      keep[1] = 1'b0;

      // wrap: ptr=2, req0 and req2 valid -> 2 then 0
      push(2, 0, 1);
      push(0, 2, 3);
      serve(0, 0);
      serve(1, 0);

      // reset after 2 of 5 beats of a req1 job (ptr=1)
      push(1, 4, 5);
      serve(0, 2);
      exp_q.delete();
      push(0, 2, 3);
      push(1, 4, 5);
      @(negedge clk);
      chk("rst_hold_rdy", bus.req_rdy_o, 0);
      chk("rst_hold_busy", bus.busy_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      serve(0, 0);
      serve(0, 0);

      // length mismatch (last on beat 3 of len 4), then a correct one
      push(0, 4, 3);
      serve(0, 0);
      push(0, 4, 5);
      serve(0, 0);

      chk("sb_drained", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
